// File: rtl/alu_pkg.sv
// Shared ALU control encodings and execute-unit state type.
// Both this unit and ALU control decode import these codes.
package alu_pkg;

  localparam logic [2:0] ALU_ZERO = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLL  = 3'd3;
  localparam logic [2:0] ALU_ADD  = 3'd4;
  localparam logic [2:0] ALU_SUB  = 3'd5;
  localparam logic [2:0] ALU_MUL  = 3'd6;
  localparam logic [2:0] ALU_SRA  = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier that consumes MUL_STEP multiplier bits per cycle.
// ALU_MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CNT_W = $clog2(STEPS) + 1;

  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] partial, acc_next, b_next;
  logic             last, finish;

  function automatic logic [WIDTH-1:0] shift_add(input logic [WIDTH-1:0] a,
                                                 input logic [MUL_STEP-1:0] digit);
    logic [WIDTH-1:0] sum;
    sum = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (digit[i]) sum = sum + (a << i);
    end
    return sum;
  endfunction

  always_comb begin
    partial  = shift_add(a_q, b_q[MUL_STEP-1:0]);
    acc_next = acc_q + partial;
    b_next   = b_q >> MUL_STEP;
    last     = (cnt_q == CNT_W'(STEPS - 1));
`ifdef ALU_MUL_EARLY_TERM_EN
    finish   = last | (b_next == '0);
`else
    finish   = last;
`endif
  end

  assign done    = busy_q & ~abort & finish;
  assign product = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= op_a;
      b_q    <= op_b;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (abort) begin
        busy_q <= 1'b0;
      end else begin
        a_q   <= a_q << MUL_STEP;
        b_q   <= b_next;
        acc_q <= acc_next;
        if (cnt_q != CNT_W'(STEPS)) cnt_q <= cnt_q + 1'b1;
        if (finish) busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_iter_exec.sv
// EX-stage execution unit: registered single-cycle ops plus an iterative MUL that stalls via ready_o.
// ALU_MUL_EARLY_TERM_EN (in alu_mul_iter) enables operand-dependent MUL latency.
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int SH_W = $clog2(WIDTH);

  alu_state_e       state;
  logic             accept, mul_start, mul_abort, mul_done;
  logic [WIDTH-1:0] single_res, product;

  function automatic logic [WIDTH-1:0] alu_single(input logic [2:0]       ctrl,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic [SH_W-1:0]         sh;
    logic [WIDTH-1:0]        res;
    sa = a;
    sh = b[SH_W-1:0];
    case (ctrl)
      ALU_AND: res = a & b;
      ALU_XOR: res = a ^ b;
      ALU_SLL: res = a << sh;
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_SRA: res = sa >>> sh;
      default: res = '0;
    endcase
    return res;
  endfunction

  always_comb begin
    accept     = valid_i & ready_o & ~flush_i;
    mul_start  = accept & (ALUCtrl_i == ALU_MUL);
    mul_abort  = (state == MUL) & flush_i;
    single_res = alu_single(ALUCtrl_i, data1_i, data2_i);
  end

  alu_mul_iter #(
    .WIDTH    (WIDTH),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (mul_start),
    .abort   (mul_abort),
    .op_a    (data1_i),
    .op_b    (data2_i),
    .done    (mul_done),
    .product (product)
  );

  // Completion: register result and pulse valid_o; flush during MUL drops the result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mul_start) begin
            state   <= MUL;
            ready_o <= 1'b0;
          end else if (accept) begin
            data_o  <= single_res;
            valid_o <= 1'b1;
          end
        end
        MUL: begin
          if (flush_i) begin
            state   <= IDLE;
            ready_o <= 1'b1;
          end else if (mul_done) begin
            data_o  <= product;
            valid_o <= 1'b1;
            state   <= IDLE;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed scoreboard bench for alu_iter_exec (default WIDTH=32, MUL_STEP=4).
module tb_alu_iter_exec;
  import alu_pkg::*;

  localparam int WIDTH    = 32;
  localparam int MUL_STEP = 4;

  logic              clk = 1'b0;
  logic              rst_i, valid_i, flush_i;
  logic [2:0]        ALUCtrl_i;
  logic [WIDTH-1:0]  data1_i, data2_i;
  logic              ready_o, valid_o;
  logic [WIDTH-1:0]  data_o;

  int                compared   = 0;
  int                mismatched = 0;
  logic [WIDTH-1:0]  exp_q[$];
  logic [WIDTH-1:0]  last_res;
  logic [63:0]       wide;

  always #5 clk = ~clk;

  alu_iter_exec #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .flush_i   (flush_i),
    .valid_o   (valid_o),
    .data_o    (data_o)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int mul_lat(input logic [WIDTH-1:0] b);
`ifdef ALU_MUL_EARLY_TERM_EN
    int s;
    s = 0;
    do begin
      b = b >> MUL_STEP;
      s++;
    end while (b != 0);
    return s + 1;
`else
    return WIDTH / MUL_STEP + 1;
`endif
  endfunction

  task automatic run_single(input string tag, input logic [2:0] c,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] e);
    ALUCtrl_i = c; data1_i = a; data2_i = b; valid_i = 1'b1;
    exp_q.push_back(e);
    step();
    valid_i = 1'b0;
    check_bit({tag, "_valid"}, valid_o, 1'b1);
    check({tag, "_data"}, data_o, exp_q.pop_front());
    check_bit({tag, "_ready"}, ready_o, 1'b1);
    last_res = e;
    step();
    check_bit({tag, "_single_pulse"}, valid_o, 1'b0);
  endtask

  task automatic run_mul(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e);
    int lat;
    lat = mul_lat(b);
    ALUCtrl_i = ALU_MUL; data1_i = a; data2_i = b; valid_i = 1'b1;
    exp_q.push_back(e);
    step();
    valid_i = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check_bit({tag, "_busy_ready"}, ready_o, 1'b0);
      check_bit({tag, "_busy_valid"}, valid_o, 1'b0);
      step();
    end
    check_bit({tag, "_valid"}, valid_o, 1'b1);
    check({tag, "_data"}, data_o, exp_q.pop_front());
    check_bit({tag, "_ready"}, ready_o, 1'b1);
    last_res = e;
    step();
    check_bit({tag, "_single_pulse"}, valid_o, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    ALUCtrl_i = ALU_ZERO; data1_i = '0; data2_i = '0; last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_ready", ready_o, 1'b1);
    check_bit("rst_valid", valid_o, 1'b0);
    check("rst_data", data_o, 32'h0);
    rst_i = 1'b0;
    step();

    // ADD then SUB back-to-back
    ALUCtrl_i = ALU_ADD; data1_i = 32'd7; data2_i = 32'd5; valid_i = 1'b1;
    exp_q.push_back(32'd12);
    step();
    check_bit("add_valid", valid_o, 1'b1);
    check("add_data", data_o, exp_q.pop_front());
    ALUCtrl_i = ALU_SUB; data1_i = 32'd3; data2_i = 32'd5;
    exp_q.push_back(32'hFFFF_FFFE);
    step();
    valid_i = 1'b0;
    check_bit("sub_valid", valid_o, 1'b1);
    check("sub_data", data_o, exp_q.pop_front());
    step();
    check_bit("b2b_idle", valid_o, 1'b0);

    run_single("sra_neg",  ALU_SRA,  32'h8000_0000, 32'd4,          32'hF800_0000);
    run_single("sra_pos",  ALU_SRA,  32'h7FFF_FFF0, 32'd4,          32'h07FF_FFFF);
    run_single("sll_mask", ALU_SLL,  32'h0000_0001, 32'h0000_0025,  32'h0000_0020);
    run_single("and",      ALU_AND,  32'hF0F0_FFFF, 32'h0FF0_00FF,  32'h00F0_00FF);
    run_single("xor",      ALU_XOR,  32'hA5A5_A5A5, 32'hFFFF_0000,  32'h5A5A_A5A5);
    run_single("zero",     ALU_ZERO, 32'h0000_1234, 32'h0000_5678,  32'h0000_0000);
    run_single("add_wrap", ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001,  32'h0000_0000);

    run_mul("mul_neg3", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    run_mul("mul_9x2",  32'd9,         32'd2, 32'd18);
    run_mul("mul_by0",  32'hDEAD_BEEF, 32'd0, 32'd0);
    run_mul("mul_m1sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    wide = 64'h1234_5678 * 64'h9ABC_DEF1;
    run_mul("mul_mix",  32'h1234_5678, 32'h9ABC_DEF1, wide[31:0]);
    run_mul("mul_7x6",  32'd7, 32'd6, 32'd42);

    // Flush mid-MUL: no result, data_o keeps last value
    ALUCtrl_i = ALU_MUL; data1_i = 32'd5; data2_i = 32'h7000_0000; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    check_bit("flush_busy1", ready_o, 1'b0);
    step();
    check_bit("flush_busy2", ready_o, 1'b0);
    step();
    flush_i = 1'b1;
    check_bit("flush_busy3", ready_o, 1'b0);
    step();
    flush_i = 1'b0;
    check_bit("flush_ready", ready_o, 1'b1);
    check_bit("flush_valid", valid_o, 1'b0);
    check("flush_data", data_o, last_res);
    for (int k = 0; k < 10; k++) begin
      step();
      check_bit("flush_no_late_valid", valid_o, 1'b0);
    end

    // Flush together with valid in IDLE: request dropped
    ALUCtrl_i = ALU_ADD; data1_i = 32'd1; data2_i = 32'd1; valid_i = 1'b1; flush_i = 1'b1;
    step();
    valid_i = 1'b0; flush_i = 1'b0;
    check_bit("flush_idle_valid", valid_o, 1'b0);
    check("flush_idle_data", data_o, last_res);
    check_bit("flush_idle_ready", ready_o, 1'b1);

    // Asynchronous reset in the middle of a MUL
    ALUCtrl_i = ALU_MUL; data1_i = 32'd3; data2_i = 32'h7000_0000; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    check_bit("rstmul_busy", ready_o, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    check("rstmul_data", data_o, 32'h0);
    check_bit("rstmul_valid", valid_o, 1'b0);
    check_bit("rstmul_ready", ready_o, 1'b1);
    step();
    rst_i = 1'b0;
    step();
    run_single("post_rst_add", ALU_ADD, 32'd1, 32'd1, 32'd2);
    for (int k = 0; k < 12; k++) begin
      step();
      check_bit("post_rst_quiet", valid_o, 1'b0);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
